// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and width limits.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sadd_state_t;

    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_full_add.sv
// Single-bit full adder cell; combinational, same port shape as the half-cell family.
module full_add (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    logic p;

    assign p       = a_i ^ b_i;
    assign sum_o   = p ^ c_i;
    assign carry_o = (a_i & b_i) | (c_i & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full-adder cell with a registered
// carry, result and carry-out presented alongside a one-cycle done strobe.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sadd_state_t      state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             c_r;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;

    full_add u_fa (
        .a_i     (a_r[0]),
        .b_i     (b_r[0]),
        .c_i     (c_r),
        .sum_o   (s_bit),
        .carry_o (c_bit)
    );

    // Sum bit enters at the MSB; written as a shift of {s, acc} so WIDTH=1 needs no special case.
    assign acc_nxt = WIDTH'({s_bit, acc} >> 1);

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            c_r     <= 1'b0;
            cnt     <= '0;
            sum_o   <= '0;
            carry_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_r   <= a_i;
                        b_r   <= b_i;
                        c_r   <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_nxt;
                    a_r <= a_r >> 1;
                    b_r <= b_r >> 1;
                    c_r <= c_bit;
                    cnt <= cnt + CW'(1);
                    // Outputs only move here, so they hold steady through the whole SHIFT phase.
                    if (cnt == CNT_LAST) begin
                        sum_o   <= acc_nxt;
                        carry_o <= c_bit;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances against an integer-add model.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic       a1, b1;
    logic       busy8, done8, carry8;
    logic [7:0] sum8;
    logic       busy1, done1, carry1;
    logic [0:0] sum1;
    int         checks   = 0;
    int         failures = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .carry_o(carry8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(a1), .b_i(b1),
        .busy_o(busy1), .done_o(done1), .sum_o(sum1), .carry_o(carry1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Runs one WIDTH=8 operation; operand inputs are scrambled after the start edge,
    // and an optional extra start pulse (with a_i=0xAA) is driven at cycle pulse_at.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input int pulse_at,
                          output int lat, output int busy_n, output int done_n,
                          output logic [7:0] s, output logic c);
        lat = 0; busy_n = 0; done_n = 0; s = '0; c = 1'b0;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 14; i++) begin
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                if (lat == 0) begin
                    lat = i; s = sum8; c = carry8;
                end
            end
            start8 = (i == pulse_at);
            if (pulse_at > 0 && i >= pulse_at) a8 = 8'hAA;
            else a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        int lat, bn, dn; logic [7:0] s; logic c;
        #12;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || carry8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold busy=%b done=%b sum=%h carry=%b exp 0/0/00/0", busy8, done8, sum8, carry8);
        end
        @(negedge clk); rst = 1'b0;
        do_op8(8'hFF, 8'hFF, 0, lat, bn, dn, s, c);
        // Assert reset mid-cycle and check before any further clock edge.
        @(posedge clk); #3; rst = 1'b1; #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || carry8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async busy=%b done=%b sum=%h carry=%b exp 0/0/00/0", busy8, done8, sum8, carry8);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bn, dn; logic [7:0] s; logic c;
        do_op8(8'h5A, 8'h3C, 0, lat, bn, dn, s, c);
        checks++;
        if (lat !== 9 || bn !== 9 || dn !== 1) begin
            failures++;
            $display("FAIL basic_timing lat=%0d busy=%0d dones=%0d exp 9/9/1", lat, bn, dn);
        end
        checks++;
        if (s !== 8'h96 || c !== 1'b0) begin
            failures++;
            $display("FAIL basic_sum sum=%h carry=%b exp 96/0", s, c);
        end
    endtask

    task automatic test_edges();
        int lat, bn, dn; logic [7:0] s; logic c;
        do_op8(8'hFF, 8'h01, 0, lat, bn, dn, s, c);
        checks++;
        if (s !== 8'h00 || c !== 1'b1) begin
            failures++;
            $display("FAIL edge_ff01 sum=%h carry=%b exp 00/1", s, c);
        end
        do_op8(8'hFF, 8'hFF, 0, lat, bn, dn, s, c);
        checks++;
        if (s !== 8'hFE || c !== 1'b1) begin
            failures++;
            $display("FAIL edge_ffff sum=%h carry=%b exp fe/1", s, c);
        end
        // Result must hold after done until the next completion.
        repeat (3) @(negedge clk);
        checks++;
        if (sum8 !== 8'hFE || carry8 !== 1'b1) begin
            failures++;
            $display("FAIL edge_hold sum=%h carry=%b exp fe/1", sum8, carry8);
        end
    endtask

    task automatic test_random();
        int lat, bn, dn; logic [7:0] s; logic c;
        logic [7:0] a, b; int exp;
        for (int k = 0; k < 25; k++) begin
            a = 8'($urandom); b = 8'($urandom);
            exp = int'(a) + int'(b);
            do_op8(a, b, 0, lat, bn, dn, s, c);
            checks++;
            if (s !== 8'(exp % 256) || c !== (exp >= 256) || lat !== 9 || dn !== 1) begin
                failures++;
                $display("FAIL random a=%h b=%h sum=%h carry=%b lat=%0d dones=%0d exp %h/%b/9/1",
                         a, b, s, c, lat, dn, 8'(exp % 256), exp >= 256);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, bn, dn; logic [7:0] s; logic c;
        do_op8(8'h10, 8'h20, 3, lat, bn, dn, s, c);
        checks++;
        if (s !== 8'h30 || c !== 1'b0 || dn !== 1 || lat !== 9) begin
            failures++;
            $display("FAIL ignore_start sum=%h carry=%b dones=%0d lat=%0d exp 30/0/1/9", s, c, dn, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bn, dn; logic [7:0] s; logic c;
        dn = 0;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || carry8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b sum=%h carry=%b exp 0/0/00/0", busy8, done8, sum8, carry8);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done8) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn !== 0) begin
            failures++;
            $display("FAIL reset_mid_nodone dones=%0d exp 0", dn);
        end
        do_op8(8'h01, 8'h02, 0, lat, bn, dn, s, c);
        checks++;
        if (s !== 8'h03 || c !== 1'b0 || dn !== 1) begin
            failures++;
            $display("FAIL reset_mid_next sum=%h carry=%b dones=%0d exp 03/0/1", s, c, dn);
        end
    endtask

    task automatic test_back_to_back();
        int hits[$];
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done8) begin
                hits.push_back(i);
                checks++;
                if (sum8 !== 8'h00 || carry8 !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_sum cycle=%0d sum=%h carry=%b exp 00/1", i, sum8, carry8);
                end
            end
        end
        start8 = 1'b0;
        checks++;
        if (hits.size() !== 4 || hits[0] !== 9) begin
            failures++;
            $display("FAIL b2b_count dones=%0d first=%0d exp 4/9", hits.size(), (hits.size() > 0) ? hits[0] : -1);
        end
        for (int k = 1; k < hits.size(); k++) begin
            checks++;
            if (hits[k] - hits[k-1] !== 10) begin
                failures++;
                $display("FAIL b2b_period gap=%0d exp 10", hits[k] - hits[k-1]);
            end
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_width1();
        int lat, bn;
        logic a, b;
        for (int k = 0; k < 6; k++) begin
            a = (k == 0) ? 1'b1 : 1'($urandom);
            b = (k == 0) ? 1'b1 : 1'($urandom);
            lat = 0; bn = 0;
            @(negedge clk);
            a1 = a; b1 = b; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0; a1 = ~a; b1 = ~b;
            for (int i = 1; i <= 4; i++) begin
                if (busy1) bn++;
                if (done1 && lat == 0) lat = i;
                @(negedge clk);
            end
            checks++;
            if (lat !== 2 || bn !== 2 || sum1 !== 1'(a ^ b) || carry1 !== (a & b)) begin
                failures++;
                $display("FAIL width1 a=%b b=%b lat=%0d busy=%0d sum=%b carry=%b exp 2/2/%b/%b",
                         a, b, lat, bn, sum1, carry1, a ^ b, a & b);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
        test_reset();
        test_basic();
        test_edges();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
